spi_slave_ctrl: RTL
===================

Name: spi_slave_ctrl

Overview:
- Serial front end of the SPI-slave/single-port-RAM subsystem; sits directly upstream of the RAM.
- Deserialises MOSI frames into 10-bit RAM words {opcode[1:0], payload[7:0]} and issues them with a one-cycle rx_valid pulse.
- Captures the RAM's read response (tx_data/tx_valid) and serialises it back on MISO, MSB first.
- SPI bit clock equals clk: one MOSI/MISO bit per clk cycle while SS_n is low.

Parameters:
- DATA_W, 8, RAM data width; rx_data width is DATA_W+2.

Ports:
- clk  input  1  system/SPI clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- SS_n  input  1  slave select, active-low, frames a transaction.
- MOSI  input  1  serial data in, sampled on posedge clk.
- MISO  output  1  serial data out.
- rx_data  output  DATA_W+2  word to RAM; [9:8] opcode, [7:0] address/data.
- rx_valid  output  1  one-cycle strobe qualifying rx_data.
- tx_data  input  DATA_W  read data from RAM.
- tx_valid  input  1  qualifies tx_data.

Behaviour:
- Reset (rst_n=0 at a posedge): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0, tx shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: stay while SS_n=1. SS_n=0 at edge E0 -> CHK_CMD. MOSI is ignored at E0.
- CHK_CMD, edge E1, samples the command bit on MOSI:
  - 0 -> WRITE.
  - 1 and rd_addr_seen=0 -> READ_ADD.
  - 1 and rd_addr_seen=1 -> READ_DATA.
  - SS_n=1 -> IDLE.
- WRITE / READ_ADD / READ_DATA, edges E2..E11: shift in 10 bits MSB first into a shift register.
  - On E11, rx_data <= the completed word and rx_valid=1 for exactly the cycle E11..E12, then 0.
  - The opcode is forwarded unchecked.
- READ_ADD: the E11 completion sets rd_addr_seen=1.
- READ_DATA: the E11 completion clears rd_addr_seen=0, then the block waits for tx_valid.
  - The first posedge sampling tx_valid=1 (nominally E13) loads tx_data.
  - From that edge MISO=tx_data[7], then [6]..[0] on successive edges, 8 cycles total, then MISO=0.
  - tx_valid during shifting, or outside READ_DATA, is ignored.
  - If tx_valid never arrives, MISO stays 0.
- After a frame completes, any further MOSI bits are ignored until SS_n=1.
- SS_n=1 in any non-IDLE state -> IDLE on that edge. MISO=0, bit counter cleared.
  - A partial frame produces no rx_valid and leaves rd_addr_seen unchanged.
  - If this edge is E11, the completed word still issues (rx_valid=1) before returning to IDLE.
- Back-to-back frames: IDLE needs at least one cycle with SS_n=1.
- Bit counter: 4 bits, saturates at 10, no wrap.
- Reset mid-frame behaves as at reset; an in-flight rx_valid is forced to 0 on the reset edge.

Optional Feature:
- Macro SPI_SLAVE_FRAME_ERR_EN.
- Defined: adds output frame_err (1 bit, reset 0). frame_err pulses for one cycle after the edge on which SS_n=1 aborts:
  - CHK_CMD; or
  - a receive state with fewer than 10 bits shifted; or
  - READ_DATA with the 8-bit MISO transfer started but unfinished.
- Not defined: no frame_err port; aborts are silent. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with SS_n=0 and MOSI toggling -> MISO=0, rx_valid=0, rx_data=0, state IDLE.
- Write: SS_n low, cmd 0, bits 10'h0A5 -> rx_data=10'h0A5, rx_valid high exactly one cycle after E11, MISO=0 throughout.
- Read pair:
  - Frame 1: cmd 1, 10'h2_37 -> rx_data=10'h237 pulse, rd_addr_seen=1.
  - SS_n high one cycle.
  - Frame 2: cmd 1, 10'h3_00 -> rx_data=10'h300 pulse.
  - Model returns tx_valid=1 with tx_data=8'hC6 at E13 -> MISO=1,1,0,0,0,1,1,0 on E13..E20, then 0; rd_addr_seen=0.
- Abort: SS_n high after 5 data bits of a READ_ADD frame -> no rx_valid, rd_addr_seen stays 0, IDLE next edge.
  - With SPI_SLAVE_FRAME_ERR_EN: frame_err=1 for one cycle.
- tx_valid ignored: tx_valid=1, tx_data=8'hFF asserted during a WRITE frame -> MISO stays 0, no state change.
- Reset mid-read: rst_n=0 while MISO shifting bit 3 of 8'hA5 -> next cycle MISO=0, IDLE, rd_addr_seen=0.

Source files
------------

// File: rtl/spi_slave_ctrl_if.sv
// SPI-slave bus bundle: serial pins plus the parallel word/read-data path to
// the RAM. The optional frame_err strobe exists only when
// SPI_SLAVE_FRAME_ERR_EN is defined.
interface spi_slave_ctrl_if #(parameter int DATA_W = 8);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic              frame_err;

    modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                    output MISO, rx_data, rx_valid, frame_err);
    modport master (output SS_n, MOSI, tx_data, tx_valid,
                    input  MISO, rx_data, rx_valid, frame_err);
`else
    modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                    output MISO, rx_data, rx_valid);
    modport master (output SS_n, MOSI, tx_data, tx_valid,
                    input  MISO, rx_data, rx_valid);
`endif
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the single-port RAM subsystem. Deserialises a
// command bit plus a 10-bit word {opcode, payload} per frame, strobes it to
// the RAM with rx_valid, and shifts the RAM's read data back out on MISO,
// MSB first. One SPI bit per clk cycle while SS_n is low.
// Optional macro SPI_SLAVE_FRAME_ERR_EN adds a one-cycle frame_err strobe
// after any frame aborted before it finished.
module spi_slave_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_ctrl_if.slave bus
);
    localparam int RX_W  = DATA_W + 2;
    localparam int TXC_W = $clog2(DATA_W + 1);
    localparam logic [3:0] LAST_BIT = 4'(RX_W - 1);
    localparam logic [3:0] FULL     = 4'(RX_W);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t             state, next_state;
    logic [3:0]         bit_cnt;       // saturates at FULL, never wraps
    logic [RX_W-2:0]    rx_shift;      // first RX_W-1 bits; the last comes straight from MOSI
    logic               rd_addr_seen;  // a read address went out, next read frame is data
    logic [DATA_W-1:0]  tx_shift;
    logic [TXC_W-1:0]   tx_left;       // MISO bits still to present after the current one
    logic               tx_armed;      // read word issued, waiting for tx_valid
    logic               receiving;
    logic               complete;
    logic               abort;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic               abort_err;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update from the same pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode plus the per-edge frame qualifiers.
    always_comb begin
        // NOTE: each output gets a default first so no path can infer a latch.
        next_state = state;
        abort      = (state != IDLE) && bus.SS_n;
        receiving  = (state == WRITE || state == READ_ADD || state == READ_DATA)
                     && (bit_cnt != FULL);
        complete   = receiving && (bit_cnt == LAST_BIT);
        case (state)
            IDLE:    if (!bus.SS_n) next_state = CHK_CMD;
            CHK_CMD: begin
                if (bus.SS_n)          next_state = IDLE;
                else if (!bus.MOSI)    next_state = WRITE;
                else if (rd_addr_seen) next_state = READ_DATA;
                else                   next_state = READ_ADD;
            end
            default: if (bus.SS_n) next_state = IDLE;
        endcase
`ifdef SPI_SLAVE_FRAME_ERR_EN
        // An abort on the completing edge still delivers the word, so only
        // strictly fewer than LAST_BIT bits held counts as short.
        abort_err = abort && ((state == CHK_CMD)
                              || (receiving && bit_cnt < LAST_BIT)
                              || (state == READ_DATA && tx_left != '0));
`endif
    end

    // Receive shifting, word issue, read-address tracking and MISO serialisation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rd_addr_seen <= 1'b0;
            tx_shift     <= '0;
            tx_left      <= '0;
            tx_armed     <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.MISO     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            bus.frame_err <= 1'b0;
`endif
        end else begin
            bus.rx_valid <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            bus.frame_err <= abort_err;
`endif
            if (receiving) rx_shift <= {rx_shift[RX_W-3:0], bus.MOSI};

            if (abort)          bit_cnt <= '0;
            else if (receiving) bit_cnt <= bit_cnt + 4'd1;

            // The completing edge issues the word even if SS_n rises on it.
            if (complete) begin
                bus.rx_data  <= {rx_shift, bus.MOSI};
                bus.rx_valid <= 1'b1;
                if (state == READ_ADD)       rd_addr_seen <= 1'b1;
                else if (state == READ_DATA) rd_addr_seen <= 1'b0;
            end

            if (abort) begin
                tx_armed <= 1'b0;
                tx_left  <= '0;
                bus.MISO <= 1'b0;
            end else if (tx_armed && bus.tx_valid) begin
                tx_armed <= 1'b0;
                bus.MISO <= bus.tx_data[DATA_W-1];
                tx_shift <= {bus.tx_data[DATA_W-2:0], 1'b0};
                tx_left  <= TXC_W'(DATA_W - 1);
            end else begin
                if (complete && state == READ_DATA) tx_armed <= 1'b1;
                if (tx_left != '0) begin
                    bus.MISO <= tx_shift[DATA_W-1];
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    tx_left  <= tx_left - 1'b1;
                end else begin
                    bus.MISO <= 1'b0;
                end
            end
        end
    end
endmodule
